// File: rtl/spike_packer.sv
// Spike bitmap to serial neuron-index stream feeding the spike queue, lowest index first.
// Optional end-of-timestep marker entry (all ones) is enabled by defining SPIKE_PACKER_EOF_EN.
module spike_packer #(
    parameter int NEURONS  = 64,
    parameter int ID_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [NEURONS-1:0]  spikes_i,
    input  logic                full_i,
    output logic                insert_o,
    output logic [ID_WIDTH-1:0] data_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [ID_WIDTH-1:0] count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [NEURONS-1:0] PEND_ONE = NEURONS'(1);

    state_t              r_state;
    state_t              w_nextState;
    logic [NEURONS-1:0]  r_pend;
    logic [NEURONS-1:0]  w_lowBit;
    logic [ID_WIDTH-1:0] w_lowIdx;
    logic [ID_WIDTH-1:0] r_count;
    logic                w_pendAny;
    logic                w_scanEnd;
`ifdef SPIKE_PACKER_EOF_EN
    logic                r_eofSent;
`endif

    // Isolating the lowest set bit with two's complement keeps the clear a single AND.
    assign w_pendAny = |r_pend;
    assign w_lowBit  = r_pend & (~r_pend + PEND_ONE);

    always_comb begin
        w_lowIdx = '0;
        for (int n = NEURONS - 1; n >= 0; n--) begin
            if (r_pend[n]) begin
                w_lowIdx = ID_WIDTH'(n);
            end
        end
    end

`ifdef SPIKE_PACKER_EOF_EN
    assign w_scanEnd = !w_pendAny && r_eofSent;
`else
    assign w_scanEnd = !w_pendAny;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        insert_o    = 1'b0;
        data_o      = '0;
        done_o      = 1'b0;
        busy_o      = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_nextState = SCAN;
                end
            end
            SCAN: begin
                if (w_scanEnd) begin
                    w_nextState = DONE;
                end
                if (w_pendAny && !full_i) begin
                    insert_o = 1'b1;
                    data_o   = w_lowIdx;
                end
`ifdef SPIKE_PACKER_EOF_EN
                else if (!w_pendAny && !r_eofSent && !full_i) begin
                    insert_o = 1'b1;
                    data_o   = '1;
                end
`endif
            end
            DONE: begin
                done_o      = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // The marker is never counted; only real neuron indices advance the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend    <= '0;
            r_count   <= '0;
`ifdef SPIKE_PACKER_EOF_EN
            r_eofSent <= 1'b0;
`endif
        end else if (r_state == IDLE && start_i) begin
            r_pend    <= spikes_i;
            r_count   <= '0;
`ifdef SPIKE_PACKER_EOF_EN
            r_eofSent <= 1'b0;
`endif
        end else if (r_state == SCAN && insert_o) begin
            if (w_pendAny) begin
                r_pend  <= r_pend & ~w_lowBit;
                r_count <= r_count + ID_WIDTH'(1);
            end
`ifdef SPIKE_PACKER_EOF_EN
            else begin
                r_eofSent <= 1'b1;
            end
`endif
        end
    end

    assign count_o = r_count;

endmodule

// File: tb/tb_spike_packer.sv
// Scoreboard bench for spike_packer: expected index/cycle pairs are queued at start and popped on each insert.
module tb_spike_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [63:0] spikes_i = '0;
    logic        full_i = 1'b0;
    logic        insert_o;
    logic [7:0]  data_o;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  count_o;

    typedef struct {
        logic [7:0] id;
        int         cyc;
    } exp_t;

    exp_t sbQueue[$];
    exp_t monEntry;
    int   checks = 0;
    int   errors = 0;
    int   curCycle = 0;

    spike_packer #(.NEURONS(64), .ID_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .spikes_i (spikes_i),
        .full_i   (full_i),
        .insert_o (insert_o),
        .data_o   (data_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .count_o  (count_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Every insert must match the head of the scoreboard in both value and cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (insert_o) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("extra_insert", 64'(data_o), 64'h100);
                end else begin
                    monEntry = sbQueue.pop_front();
                    checkOutput("insert_data", 64'(data_o), 64'(monEntry.id));
                    checkOutput("insert_cycle", 64'(curCycle), 64'(monEntry.cyc));
                end
            end else begin
                checkOutput("idle_data", 64'(data_o), 64'h0);
            end
        end
    end

    // Runs one scan; full_i is held high during cycles fs..fs+fl-1, midStart re-pulses start in cycle 2.
    task automatic applyStimulus(input logic [63:0] bitmap, input int fs, input int fl, input bit midStart);
        int   k = 0;
        int   expDone;
        int   doneCyc = -1;
        exp_t e;
        for (int n = 0; n < 64; n++) begin
            if (bitmap[n]) begin
                k++;
                e.id  = 8'(n);
                e.cyc = (k < fs) ? k : k + fl;
                sbQueue.push_back(e);
            end
        end
`ifdef SPIKE_PACKER_EOF_EN
        e.id  = 8'hFF;
        e.cyc = (k + 1 < fs) ? k + 1 : k + 1 + fl;
        sbQueue.push_back(e);
        expDone = k + 3 + fl;
`else
        expDone = k + 2 + fl;
`endif
        @(posedge clk); #1;
        start_i  = 1'b1;
        spikes_i = bitmap;
        full_i   = 1'b0;
        curCycle = 0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk); #1;
            curCycle = cyc;
            start_i  = midStart && (cyc == 2);
            if (start_i) spikes_i = ~bitmap;
            full_i   = (cyc >= fs) && (cyc < fs + fl);
            @(negedge clk);
            if (done_o) begin
                doneCyc = cyc;
                break;
            end
        end
        checkOutput("done_cycle", 64'(doneCyc), 64'(expDone));
        checkOutput("busy_at_done", 64'(busy_o), 64'h1);
        checkOutput("count", 64'(count_o), 64'(k));
        checkOutput("sb_drained", 64'(sbQueue.size()), 64'h0);
        sbQueue.delete();
        @(posedge clk); #1;
        start_i = 1'b0;
        full_i  = 1'b0;
        @(negedge clk);
        checkOutput("done_pulse", 64'(done_o), 64'h0);
        checkOutput("busy_idle", 64'(busy_o), 64'h0);
        checkOutput("count_hold", 64'(count_o), 64'(k));
    endtask

    initial begin
        logic [63:0] rstMap;
        logic        doneSeen;
        exp_t        e;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_insert", 64'(insert_o), 64'h0);
        checkOutput("reset_data", 64'(data_o), 64'h0);
        checkOutput("reset_busy", 64'(busy_o), 64'h0);
        checkOutput("reset_done", 64'(done_o), 64'h0);
        checkOutput("reset_count", 64'(count_o), 64'h0);

        applyStimulus(64'h0000_0000_0000_0016, 0, 0, 1'b0);
        applyStimulus(64'h0, 0, 0, 1'b0);
        applyStimulus(64'h8000_0000_0000_0001, 1, 3, 1'b0);
        applyStimulus({64{1'b1}}, 10, 4, 1'b0);
        applyStimulus(64'h0000_0000_0000_0F0C, 0, 0, 1'b1);

        // Reset in cycle 2 of a five-spike scan discards the remaining bits.
        rstMap = 64'h0000_1000_0000_0305;
        e.id = 8'd0;
        e.cyc = 1;
        sbQueue.push_back(e);
        @(posedge clk); #1;
        start_i  = 1'b1;
        spikes_i = rstMap;
        curCycle = 0;
        @(posedge clk); #1;
        start_i  = 1'b0;
        curCycle = 1;
        @(posedge clk); #1;
        curCycle = 2;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        curCycle = 3;
        @(negedge clk);
        checkOutput("rst_mid_insert", 64'(insert_o), 64'h0);
        checkOutput("rst_mid_count", 64'(count_o), 64'h0);
        checkOutput("rst_mid_busy", 64'(busy_o), 64'h0);
        checkOutput("rst_mid_sb", 64'(sbQueue.size()), 64'h0);
        sbQueue.delete();
        doneSeen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            doneSeen = doneSeen | done_o;
        end
        checkOutput("rst_mid_no_done", 64'(doneSeen), 64'h0);
        applyStimulus(rstMap, 0, 0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            applyStimulus({$urandom, $urandom}, 0, 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
